// File: rtl/rgbw_frame_pkg.sv
// Shared types and constants for the RGBW frame sender.
// Frame length depends on RGBW_FRAME_CHECKSUM_EN (adds a trailing XOR byte when defined).
package rgbw_frame_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;

`ifdef RGBW_FRAME_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 9;
`else
    localparam int unsigned FRAME_BYTES = 8;
`endif

    typedef logic [3:0] byte_idx_t;

    localparam byte_idx_t IDX_SYNC  = 4'd0;
    localparam byte_idx_t IDX_LINT  = 4'd1;
    localparam byte_idx_t IDX_COLOR = 4'd2;
    localparam byte_idx_t IDX_RED   = 4'd3;
    localparam byte_idx_t IDX_GREEN = 4'd4;
    localparam byte_idx_t IDX_BLUE  = 4'd5;
    localparam byte_idx_t IDX_WHITE = 4'd6;
    localparam byte_idx_t IDX_MODE  = 4'd7;
`ifdef RGBW_FRAME_CHECKSUM_EN
    localparam byte_idx_t IDX_CSUM  = 4'd8;
`endif
    localparam byte_idx_t IDX_LAST  = byte_idx_t'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP,
        ST_FINISH
    } state_e;

    typedef struct packed {
        logic [7:0] lint;
        logic [7:0] color_idx;
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
        logic [7:0] white;
        logic [7:0] mode;
    } payload_t;

`ifdef RGBW_FRAME_CHECKSUM_EN
    function automatic logic [7:0] payload_xor(payload_t p);
        return p.lint ^ p.color_idx ^ p.red ^ p.green ^ p.blue ^ p.white ^ p.mode;
    endfunction
`endif

endpackage

// File: rtl/rgbw_frame_sender_if.sv
// Request/payload and SPI-side signals of the RGBW frame sender.
// The slave modport is the sender itself; master is whoever requests frames.
interface rgbw_frame_sender_if;

    logic       start;
    logic [7:0] lint;
    logic [7:0] color_idx;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [7:0] white;
    logic [7:0] mode;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       cs_n;

    modport master (
        output start, lint, color_idx, red, green, blue, white, mode,
        input  busy, done, sclk, mosi, cs_n
    );

    modport slave (
        input  start, lint, color_idx, red, green, blue, white, mode,
        output busy, done, sclk, mosi, cs_n
    );

endinterface

// File: rtl/rgbw_frame_sender_spi_byte_shifter.sv
// Per-byte SPI mode-0 shifter: SCLK half-period timing, MSB-first shift, next-byte load.
// The next byte is taken from data_i on the falling edge of the current byte's last bit.
module spi_byte_shifter #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       byte_done_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] sr_q, sr_d;
    logic [7:0] div_q, div_d;
    logic [2:0] bit_q, bit_d;
    logic       high_q, high_d;
    logic       tc;

    assign tc = (div_q == 8'd0);

    always_comb begin
        sr_d        = sr_q;
        div_d       = div_q;
        bit_d       = bit_q;
        high_d      = high_q;
        byte_done_o = 1'b0;
        if (load_i) begin
            sr_d   = data_i;
            div_d  = DIV_LAST;
            bit_d  = 3'd7;
            high_d = 1'b1;
        end else if (en_i) begin
            if (!tc) begin
                div_d = div_q - 8'd1;
            end else begin
                div_d = DIV_LAST;
                if (high_q) begin
                    // falling edge: advance to the next bit, or the next byte's MSB
                    high_d = 1'b0;
                    sr_d   = (bit_q == 3'd0) ? data_i : {sr_q[6:0], 1'b0};
                end else if (bit_q == 3'd0) begin
                    byte_done_o = 1'b1;
                    high_d      = 1'b1;
                    bit_d       = 3'd7;
                end else begin
                    high_d = 1'b1;
                    bit_d  = bit_q - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q   <= 8'd0;
            div_q  <= 8'd0;
            bit_q  <= 3'd0;
            high_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            high_q <= high_d;
        end
    end

    assign sclk_o = en_i & high_q;
    assign mosi_o = sr_q[7];

endmodule

// File: rtl/rgbw_frame_sender.sv
// RGBW frame sender: snapshots payload on start and sends sync + payload bytes over SPI.
// States: IDLE wait | SETUP cs low, MSB out | SHIFT bytes | GAP inter-byte idle | FINISH done pulse.
// Define RGBW_FRAME_CHECKSUM_EN to append an XOR checksum byte.
module rgbw_frame_sender
    import rgbw_frame_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 4
) (
    input logic                clk,
    input logic                reset,
    rgbw_frame_sender_if.slave bus_if
);

    localparam logic [15:0] SETUP_LAST = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    state_e      state_q, state_d;
    payload_t    snap_q, snap_d;
    byte_idx_t   byte_q, byte_d;
    logic [15:0] tmr_q, tmr_d;
`ifdef RGBW_FRAME_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    payload_t    live;
    byte_idx_t   next_idx;
    logic [7:0]  next_byte;
    logic        load;
    logic        shift_en;
    logic        byte_done;
    logic        sh_sclk;
    logic        sh_mosi;
    logic        active;

    assign live = '{lint:      bus_if.lint,
                    color_idx: bus_if.color_idx,
                    red:       bus_if.red,
                    green:     bus_if.green,
                    blue:      bus_if.blue,
                    white:     bus_if.white,
                    mode:      bus_if.mode};

    // Outside SHIFT the only byte ever loaded is the sync byte at frame start.
    always_comb begin
        next_idx  = byte_q + 4'd1;
        next_byte = 8'h00;
        if (state_q != ST_SHIFT) begin
            next_byte = SYNC_BYTE;
        end else begin
            case (next_idx)
                IDX_SYNC:  next_byte = SYNC_BYTE;
                IDX_LINT:  next_byte = snap_q.lint;
                IDX_COLOR: next_byte = snap_q.color_idx;
                IDX_RED:   next_byte = snap_q.red;
                IDX_GREEN: next_byte = snap_q.green;
                IDX_BLUE:  next_byte = snap_q.blue;
                IDX_WHITE: next_byte = snap_q.white;
                IDX_MODE:  next_byte = snap_q.mode;
`ifdef RGBW_FRAME_CHECKSUM_EN
                IDX_CSUM:  next_byte = csum_q;
`endif
                default:   next_byte = 8'h00;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        byte_d   = byte_q;
        tmr_d    = tmr_q;
        load     = 1'b0;
        shift_en = 1'b0;
`ifdef RGBW_FRAME_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_FINISH: begin
                if (bus_if.start) begin
                    state_d = ST_SETUP;
                    snap_d  = live;
                    byte_d  = IDX_SYNC;
                    tmr_d   = SETUP_LAST;
                    load    = 1'b1;
`ifdef RGBW_FRAME_CHECKSUM_EN
                    csum_d  = payload_xor(live);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_q == 16'd0) state_d = ST_SHIFT;
                else                tmr_d   = tmr_q - 16'd1;
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (byte_done) begin
                    if (byte_q == IDX_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        byte_d = byte_q + 4'd1;
                        if (GAP_CYCLES != 0) begin
                            state_d = ST_GAP;
                            tmr_d   = GAP_LAST;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tmr_q == 16'd0) state_d = ST_SHIFT;
                else                tmr_d   = tmr_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            byte_q  <= '0;
            tmr_q   <= 16'd0;
`ifdef RGBW_FRAME_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            byte_q  <= byte_d;
            tmr_q   <= tmr_d;
`ifdef RGBW_FRAME_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .en_i        (shift_en),
        .data_i      (next_byte),
        .sclk_o      (sh_sclk),
        .mosi_o      (sh_mosi),
        .byte_done_o (byte_done)
    );

    assign active      = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_GAP);
    assign bus_if.busy = active;
    assign bus_if.cs_n = ~active;
    assign bus_if.done = (state_q == ST_FINISH);
    assign bus_if.sclk = sh_sclk;
    assign bus_if.mosi = active & sh_mosi;

endmodule

// File: tb/tb_rgbw_frame_sender.sv
// Directed bench for rgbw_frame_sender: default instance plus a CLK_DIV=1, GAP_CYCLES=0 instance.
// A negedge monitor decodes SPI bytes and cs_n-low lengths; checks are immediate assertions.
module tb_rgbw_frame_sender;

    localparam int DIV0 = 2;
    localparam int GAP0 = 4;
`ifdef RGBW_FRAME_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int LEN0 = DIV0 + NB * 16 * DIV0 + (NB - 1) * GAP0;
    localparam int LEN1 = 1 + NB * 16;

    logic       clk;
    logic       reset;
    logic       st [2];
    logic [7:0] pay [7];
    logic [7:0] exp_b [9];

    int checks = 0;
    int errors = 0;

    rgbw_frame_sender_if bus0 ();
    rgbw_frame_sender_if bus1 ();

    assign bus0.start     = st[0];
    assign bus0.lint      = pay[0];
    assign bus0.color_idx = pay[1];
    assign bus0.red       = pay[2];
    assign bus0.green     = pay[3];
    assign bus0.blue      = pay[4];
    assign bus0.white     = pay[5];
    assign bus0.mode      = pay[6];
    assign bus1.start     = st[1];
    assign bus1.lint      = pay[0];
    assign bus1.color_idx = pay[1];
    assign bus1.red       = pay[2];
    assign bus1.green     = pay[3];
    assign bus1.blue      = pay[4];
    assign bus1.white     = pay[5];
    assign bus1.mode      = pay[6];

    rgbw_frame_sender #(.CLK_DIV(DIV0), .GAP_CYCLES(GAP0)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus0)
    );

    rgbw_frame_sender #(.CLK_DIV(1), .GAP_CYCLES(0)) u_fast (
        .clk    (clk),
        .reset  (reset),
        .bus_if (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic sclk_v [2], mosi_v [2], csn_v [2], done_v [2], busy_v [2];
    assign sclk_v[0] = bus0.sclk;  assign sclk_v[1] = bus1.sclk;
    assign mosi_v[0] = bus0.mosi;  assign mosi_v[1] = bus1.mosi;
    assign csn_v[0]  = bus0.cs_n;  assign csn_v[1]  = bus1.cs_n;
    assign done_v[0] = bus0.done;  assign done_v[1] = bus1.done;
    assign busy_v[0] = bus0.busy;  assign busy_v[1] = bus1.busy;

    int         run_len [2]  = '{0, 0};
    int         last_len [2] = '{0, 0};
    int         frames [2]   = '{0, 0};
    int         done_cnt [2] = '{0, 0};
    int         stab_err [2] = '{0, 0};
    int         nbytes [2]   = '{0, 0};
    int         bitn [2]     = '{0, 0};
    logic       prev_sclk [2] = '{1'b0, 1'b0};
    logic       prev_mosi [2] = '{1'b0, 1'b0};
    logic [7:0] shreg [2];
    logic [7:0] cap [2][512];

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_v[k]) done_cnt[k] = done_cnt[k] + 1;
            if (!csn_v[k]) begin
                run_len[k] = run_len[k] + 1;
                if (sclk_v[k] && !prev_sclk[k]) begin
                    if (mosi_v[k] !== prev_mosi[k]) stab_err[k] = stab_err[k] + 1;
                    shreg[k] = {shreg[k][6:0], mosi_v[k]};
                    bitn[k]  = bitn[k] + 1;
                    if (bitn[k] == 8) begin
                        if (nbytes[k] < 512) cap[k][nbytes[k]] = shreg[k];
                        nbytes[k] = nbytes[k] + 1;
                        bitn[k]   = 0;
                    end
                end
            end else begin
                bitn[k] = 0;
                if (run_len[k] != 0) begin
                    last_len[k] = run_len[k];
                    frames[k]   = frames[k] + 1;
                    run_len[k]  = 0;
                end
            end
            prev_sclk[k] = sclk_v[k];
            prev_mosi[k] = mosi_v[k];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, expv);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int k, input int limit, input string tag);
        int n = 0;
        while (!done_v[k] && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk1({tag, "_done_seen"}, done_v[k], 1'b1);
    endtask

    // Expected frame from the payload currently applied: sync, seven bytes, optional XOR.
    task automatic set_exp();
        logic [7:0] x = 8'h00;
        exp_b[0] = 8'h55;
        for (int i = 0; i < 7; i++) begin
            exp_b[i + 1] = pay[i];
            x = x ^ pay[i];
        end
        exp_b[8] = x;
    endtask

    task automatic chk_frame(input int k, input int base, input string tag);
        for (int i = 0; i < NB; i++)
            chk8($sformatf("%s_byte%0d", tag, i), cap[k][base + i], exp_b[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int fr;
        int dn;

        reset = 1'b0;
        st[0] = 1'b0;
        st[1] = 1'b0;
        pay   = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        tick(3);
        chk1("rst_cs_n", bus0.cs_n, 1'b1);
        chk1("rst_sclk", bus0.sclk, 1'b0);
        chk1("rst_mosi", bus0.mosi, 1'b0);
        chk1("rst_busy", bus0.busy, 1'b0);
        chk1("rst_done", bus0.done, 1'b0);
        reset = 1'b1;
        tick(2);

        // Basic frame
        pay = '{8'h80, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h02};
        set_exp();
        base = nbytes[0]; fr = frames[0]; dn = done_cnt[0];
        st[0] = 1'b1;
        tick(1);
        chk1("setup_busy", bus0.busy, 1'b1);
        chk1("setup_cs_n", bus0.cs_n, 1'b0);
        chk1("setup_sclk", bus0.sclk, 1'b0);
        chk1("setup_mosi", bus0.mosi, 1'b0);
        st[0] = 1'b0;
        wait_done(0, 600, "f1");
        chk1("fin_cs_n", bus0.cs_n, 1'b1);
        chk1("fin_busy", bus0.busy, 1'b0);
        chk1("fin_sclk", bus0.sclk, 1'b0);
        chk1("fin_mosi", bus0.mosi, 1'b0);
        tick(1);
        chk1("done_one_cycle", bus0.done, 1'b0);
        chk_frame(0, base, "f1");
        chkn("f1_cs_len", last_len[0], LEN0);
        chkn("f1_done_cnt", done_cnt[0] - dn, 1);
        chkn("f1_frames", frames[0] - fr, 1);

        // Start re-pulsed and payload changed mid-frame
        pay = '{8'hA5, 8'h10, 8'hFE, 8'h00, 8'h7F, 8'hC3, 8'h3C};
        set_exp();
        base = nbytes[0]; fr = frames[0];
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        tick(DIV0 + 3 * (16 * DIV0 + GAP0) + 5);
        chk1("f2_busy_in_byte3", bus0.busy, 1'b1);
        st[0] = 1'b1;
        for (int i = 0; i < 7; i++) pay[i] = ~pay[i];
        tick(1);
        st[0] = 1'b0;
        wait_done(0, 600, "f2");
        tick(1);
        chk_frame(0, base, "f2");
        chkn("f2_cs_len", last_len[0], LEN0);
        tick(40);
        chk1("f2_no_restart", bus0.busy, 1'b0);
        chkn("f2_frames", frames[0] - fr, 1);
        chkn("f2_nbytes", nbytes[0] - base, NB);

        // start held high: back-to-back frames
        pay = '{8'h0F, 8'hF0, 8'h5A, 8'h96, 8'h01, 8'h80, 8'hEE};
        set_exp();
        base = nbytes[0]; fr = frames[0]; dn = done_cnt[0];
        st[0] = 1'b1;
        wait_done(0, 600, "b2b1");
        chk1("b2b_fin_cs_n", bus0.cs_n, 1'b1);
        tick(1);
        chk1("b2b_setup_busy", bus0.busy, 1'b1);
        chk1("b2b_setup_cs_n", bus0.cs_n, 1'b0);
        st[0] = 1'b0;
        wait_done(0, 600, "b2b2");
        tick(1);
        chk_frame(0, base, "b2b_a");
        chk_frame(0, base + NB, "b2b_b");
        chkn("b2b_frames", frames[0] - fr, 2);
        chkn("b2b_done_cnt", done_cnt[0] - dn, 2);
        chkn("b2b_cs_len", last_len[0], LEN0);
        tick(5);
        chk1("b2b_idle", bus0.busy, 1'b0);

        // Reset during byte 4, with start asserted while reset is low
        pay = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE};
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        dn = done_cnt[0];
        tick(DIV0 + 4 * (16 * DIV0 + GAP0) + 6);
        chk1("abort_busy_before", bus0.busy, 1'b1);
        reset = 1'b0;
        st[0] = 1'b1;
        tick(1);
        chk1("abort_cs_n", bus0.cs_n, 1'b1);
        chk1("abort_sclk", bus0.sclk, 1'b0);
        chk1("abort_mosi", bus0.mosi, 1'b0);
        chk1("abort_busy", bus0.busy, 1'b0);
        chk1("abort_done", bus0.done, 1'b0);
        tick(1);
        reset = 1'b1;
        st[0] = 1'b0;
        tick(3);
        chk1("abort_start_ignored", bus0.busy, 1'b0);
        chkn("abort_no_done", done_cnt[0] - dn, 0);

        pay = '{8'hC0, 8'h03, 8'hFF, 8'h00, 8'hAA, 8'h55, 8'h01};
        set_exp();
        base = nbytes[0];
        st[0] = 1'b1;
        tick(1);
        st[0] = 1'b0;
        wait_done(0, 600, "after_rst");
        tick(1);
        chk_frame(0, base, "after_rst");
        chkn("after_rst_cs_len", last_len[0], LEN0);
        chkn("stable_default", stab_err[0], 0);

        // CLK_DIV=1, GAP_CYCLES=0 instance
        pay = '{8'h80, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h02};
        set_exp();
        base = nbytes[1];
        st[1] = 1'b1;
        tick(1);
        st[1] = 1'b0;
        chk1("fast_setup_cs_n", bus1.cs_n, 1'b0);
        wait_done(1, 400, "fast");
        tick(1);
        chk_frame(1, base, "fast");
        chkn("fast_cs_len", last_len[1], LEN1);
        chkn("fast_stable", stab_err[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
